// File: rtl/pond_stream_pkg.sv
// Shared constants and types for the pond stream transmitter.
package pond_stream_pkg;

   localparam int DATA_WIDTH       = 16;
   localparam int CYCLE_WIDTH      = 16;
   localparam int RANGE_WIDTH      = 5;
   localparam int ITERATOR_SUPPORT = 2;
   localparam int FIFO_DEPTH       = 4;

   typedef logic [DATA_WIDTH-1:0]  data_t;
   typedef logic [CYCLE_WIDTH-1:0] cycle_t;
   typedef logic [RANGE_WIDTH-1:0] range_t;

   // Index 0 is the inner loop level, index 1 the outer level.
   typedef logic [ITERATOR_SUPPORT-1:0][RANGE_WIDTH-1:0] ranges_t;
   typedef logic [ITERATOR_SUPPORT-1:0][CYCLE_WIDTH-1:0] strides_t;

endpackage

// File: rtl/sched_stream_fifo.sv
// Small synchronous FIFO with a combinational head; DEPTH must be a power of 2.
// Contents are not cleared on reset: an empty FIFO never exposes its storage.
module sched_stream_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_FULL);
   assign head    = mem[rd_ptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Storage write; no reset needed since occupancy is tracked separately.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Pointer and occupancy tracking; simultaneous push and pop keep count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sched_stream_tx.sv
// Schedule-driven stream transmitter for a pond write port.
// Words arrive on a valid/ready stream into a FIFO and leave one per
// scheduled cycle; the schedule is a 2-level nested-loop address sequence
// compared against a free-running cycle counter.
// Optional macro SCHED_STREAM_TX_BYPASS_EN: at a scheduled slot with an empty
// FIFO, a same-cycle input word is forwarded straight to the output.
module sched_stream_tx #(
   parameter int DATA_WIDTH       = pond_stream_pkg::DATA_WIDTH,
   parameter int FIFO_DEPTH       = pond_stream_pkg::FIFO_DEPTH,
   parameter int ITERATOR_SUPPORT = pond_stream_pkg::ITERATOR_SUPPORT,
   parameter int RANGE_WIDTH      = pond_stream_pkg::RANGE_WIDTH,
   parameter int CYCLE_WIDTH      = pond_stream_pkg::CYCLE_WIDTH
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          tile_en,
   input  logic [DATA_WIDTH-1:0]                         data_in,
   input  logic                                          valid_in,
   output logic                                          ready_out,
   input  logic [1:0]                                    dimensionality,
   input  logic [ITERATOR_SUPPORT-1:0][RANGE_WIDTH-1:0]  ranges,
   input  logic [CYCLE_WIDTH-1:0]                        sched_starting_addr,
   input  logic [ITERATOR_SUPPORT-1:0][CYCLE_WIDTH-1:0]  sched_strides,
   output logic [DATA_WIDTH-1:0]                         data_out,
   output logic                                          valid_out,
   output logic                                          done,
   output logic                                          underflow
);

   import pond_stream_pkg::*;

   localparam logic [CYCLE_WIDTH-1:0] CYCLE_ONE = CYCLE_WIDTH'(1);
   localparam logic [RANGE_WIDTH-1:0] RANGE_ONE = RANGE_WIDTH'(1);

   logic [CYCLE_WIDTH-1:0] cycle_count;
   logic [CYCLE_WIDTH-1:0] addr_off;
   logic [CYCLE_WIDTH-1:0] sched_addr;
   logic [RANGE_WIDTH-1:0] it0;
   logic [RANGE_WIDTH-1:0] it1;
   logic                   done_q;
   logic                   underflow_q;

   logic                   active;
   logic                   match;
   logic                   step_inner;
   logic                   step_outer;
   logic                   bypass;
   logic                   fifo_push;
   logic                   fifo_pop;
   logic                   fifo_empty;
   logic                   fifo_full;
   logic [DATA_WIDTH-1:0]  fifo_head;

   // The schedule address is kept as an offset from the start address so
   // that the register resets to a constant.
   assign sched_addr = sched_starting_addr + addr_off;
   assign active     = tile_en & ~rst;
   assign match      = active & ~done_q & (dimensionality != 2'd0)
                     & (cycle_count == sched_addr);

   // Inner level advances first; the outer level advances only once the
   // inner counter has reached its range.
   assign step_inner = (dimensionality != 2'd0) & (it0 != ranges[0]);
   assign step_outer = ~step_inner & (dimensionality == 2'd2) & (it1 != ranges[1]);

`ifdef SCHED_STREAM_TX_BYPASS_EN
   assign bypass = match & fifo_empty & valid_in;
`else
   assign bypass = 1'b0;
`endif

   // Input stream: a word transfers on any cycle where valid_in and ready_out
   // are both high. ready_out never looks at a same-cycle pop, so a full FIFO
   // refuses input even while it is releasing a word. A bypassed word is
   // taken by the output directly and never written into the FIFO.
   assign ready_out = (active & ~fifo_full & ~done_q) | bypass;
   assign fifo_push = valid_in & ready_out & ~bypass;
   assign fifo_pop  = match & ~fifo_empty;

   assign valid_out = fifo_pop | bypass;
   assign data_out  = bypass     ? data_in :
                      fifo_empty ? '0      : fifo_head;
   assign done      = done_q;
   assign underflow = underflow_q;

   sched_stream_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .data_in (data_in),
      .head    (fifo_head),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   // Free-running cycle counter, frozen while the tile is disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_count <= '0;
      end else if (tile_en) begin
         cycle_count <= cycle_count + CYCLE_ONE;
      end
   end

   // Loop iterator, schedule address and sticky done/underflow flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         it0         <= '0;
         it1         <= '0;
         addr_off    <= '0;
         done_q      <= 1'b0;
         underflow_q <= 1'b0;
      end else if (tile_en) begin
         if (dimensionality == 2'd0) begin
            done_q <= 1'b1;
         end
         if (match) begin
            if (step_inner) begin
               it0      <= it0 + RANGE_ONE;
               addr_off <= addr_off + sched_strides[0];
            end else if (step_outer) begin
               it0      <= '0;
               it1      <= it1 + RANGE_ONE;
               addr_off <= addr_off + sched_strides[1];
            end else begin
               done_q <= 1'b1;
            end
            if (fifo_empty & ~bypass) begin
               underflow_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sched_stream_tx.sv
// Testbench for sched_stream_tx: scenario table, corner-case sequences and
// randomized runs checked cycle by cycle against a schedule/queue model.
module tb_sched_stream_tx;

   import pond_stream_pkg::*;

   localparam int DEPTH = FIFO_DEPTH;

   logic     clk = 1'b0;
   logic     rst = 1'b1;
   logic     tile_en = 1'b0;
   logic     valid_in = 1'b0;
   data_t    data_in = '0;
   logic     ready_out;
   logic     valid_out;
   logic     done;
   logic     underflow;
   data_t    data_out;
   logic [1:0] dimensionality = '0;
   ranges_t  ranges = '0;
   strides_t sched_strides = '0;
   cycle_t   sched_starting_addr = '0;

   // Clock
   always #5 clk = ~clk;

   sched_stream_tx dut (
      .clk                 (clk),
      .rst                 (rst),
      .tile_en             (tile_en),
      .data_in             (data_in),
      .valid_in            (valid_in),
      .ready_out           (ready_out),
      .dimensionality      (dimensionality),
      .ranges              (ranges),
      .sched_starting_addr (sched_starting_addr),
      .sched_strides       (sched_strides),
      .data_out            (data_out),
      .valid_out           (valid_out),
      .done                (done),
      .underflow           (underflow)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   cycle_t sched[$];
   data_t  exp_q[$];
   cycle_t m_t;
   int     m_k;
   logic   m_done;
   logic   m_uf;

   // Per-run observations
   int     step_idx;
   int     rel_cyc[$];
   data_t  rel_dat[$];
   logic   vld_hist[$];
   logic   rdy_hist[$];
   data_t  dat_hist[$];
   int     done_step;
   int     uf_step;

   typedef struct {
      logic [1:0] dim;
      int r0, r1, st, s0, s1, push_start, npush;
      int nrel, first, last, done_cyc, uf_cyc;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h, required %0h", name, act, req);
      end
   endtask

   // All scheduled slots in order, from the nested-loop definition.
   function automatic void build_sched();
      int n1;
      int r0;
      int s0;
      sched.delete();
      if (dimensionality != 2'd0) begin
         n1 = (dimensionality == 2'd2) ? int'(ranges[1]) : 0;
         r0 = int'(ranges[0]);
         s0 = int'(sched_strides[0]);
         for (int i1 = 0; i1 <= n1; i1++) begin
            for (int i0 = 0; i0 <= r0; i0++) begin
               sched.push_back(cycle_t'(int'(sched_starting_addr)
                  + i1 * (r0 * s0 + int'(sched_strides[1])) + i0 * s0));
            end
         end
      end
   endfunction

   task automatic do_reset(input logic [1:0] dim, input int r0, input int r1,
                           input int st, input int s0, input int s1);
      rst = 1'b1;
      tile_en = 1'b1;
      valid_in = 1'b1;
      data_in = 16'h5A5A;
      dimensionality = dim;
      ranges[0] = range_t'(r0);
      ranges[1] = range_t'(r1);
      sched_starting_addr = cycle_t'(st);
      sched_strides[0] = cycle_t'(s0);
      sched_strides[1] = cycle_t'(s1);
      @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'b0, ready_out}, 32'd0);
      chk("rst_valid", {31'b0, valid_out}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_underflow", {31'b0, underflow}, 32'd0);
      chk("rst_data", {16'b0, data_out}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      valid_in = 1'b0;
      data_in = '0;
      m_t = '0;
      m_k = 0;
      m_done = 1'b0;
      m_uf = 1'b0;
      exp_q.delete();
      build_sched();
      step_idx = 0;
      rel_cyc.delete();
      rel_dat.delete();
      vld_hist.delete();
      rdy_hist.delete();
      dat_hist.delete();
      done_step = -1;
      uf_step = -1;
   endtask

   // One clock cycle: drive, compare with the model at negedge, advance model.
   task automatic step(input logic en, input logic vin, input data_t din);
      logic  m_match;
      logic  had;
      logic  byp;
      logic  e_ready;
      logic  e_valid;
      data_t e_data;
      tile_en = en;
      valid_in = vin;
      data_in = din;
      @(negedge clk);
      had = (exp_q.size() > 0);
      m_match = 1'b0;
      if (en && !m_done && m_k < sched.size()) begin
         m_match = (m_t == sched[m_k]);
      end
      byp = 1'b0;
`ifdef SCHED_STREAM_TX_BYPASS_EN
      byp = m_match && !had && vin;
`endif
      e_ready = (en && !m_done && exp_q.size() < DEPTH) || byp;
      e_valid = (m_match && had) || byp;
      e_data  = byp ? din : (had ? exp_q[0] : '0);
      chk("ready_out", {31'b0, ready_out}, {31'b0, e_ready});
      chk("valid_out", {31'b0, valid_out}, {31'b0, e_valid});
      chk("data_out", {16'b0, data_out}, {16'b0, e_data});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("underflow", {31'b0, underflow}, {31'b0, m_uf});
      vld_hist.push_back(valid_out);
      rdy_hist.push_back(ready_out);
      dat_hist.push_back(data_out);
      if (valid_out === 1'b1) begin
         rel_cyc.push_back(step_idx);
         rel_dat.push_back(data_out);
      end
      if (done === 1'b1 && done_step < 0) done_step = step_idx;
      if (underflow === 1'b1 && uf_step < 0) uf_step = step_idx;
      if (en) begin
         if (m_match && had) void'(exp_q.pop_front());
         if (vin && e_ready && !byp) exp_q.push_back(din);
         if (m_match && !had && !byp) m_uf = 1'b1;
         if (m_match) begin
            m_k++;
            if (m_k == sched.size()) m_done = 1'b1;
         end
         if (dimensionality == 2'd0) m_done = 1'b1;
         m_t++;
      end
      @(posedge clk);
      #1;
      step_idx++;
   endtask

   // Run a configuration with a contiguous push window and optional disable window.
   task automatic run_cfg(input logic [1:0] dim, input int r0, input int r1,
                          input int st, input int s0, input int s1,
                          input int push_start, input int npush,
                          input int off_start, input int off_len, input int nsteps);
      logic en;
      logic vin;
      do_reset(dim, r0, r1, st, s0, s1);
      for (int s = 0; s < nsteps; s++) begin
         en  = !(s >= off_start && s < off_start + off_len);
         vin = (s >= push_start && s < push_start + npush);
         step(en, vin, vin ? data_t'(16'hA000 + s - push_start) : data_t'(0));
      end
   endtask

   task automatic check_summary(input string tag, input int nrel, input int first,
                                input int last, input int done_cyc, input int uf_cyc);
      chk({tag, "_nrel"}, rel_cyc.size(), nrel);
      chk({tag, "_first"}, (rel_cyc.size() > 0) ? rel_cyc[0] : -1, first);
      chk({tag, "_last"}, (rel_cyc.size() > 0) ? rel_cyc[rel_cyc.size()-1] : -1, last);
      chk({tag, "_done_cyc"}, done_step, done_cyc);
      chk({tag, "_uf_cyc"}, uf_step, uf_cyc);
      for (int j = 0; j < rel_dat.size(); j++) begin
         chk({tag, "_order"}, {16'b0, rel_dat[j]}, 32'hA000 + j);
      end
   endtask

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: actual timeout, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic en;
      logic vin;

      //         dim   r0 r1 st s0 s1 ps np   nrel first last done uf
      vecs[0] = '{2'd1, 3, 0, 10, 2, 0, 1, 4,  4, 10, 16, 17, -1};
      vecs[1] = '{2'd2, 1, 1, 4,  1, 5, 0, 4,  4, 4,  11, 12, -1};
      vecs[2] = '{2'd1, 1, 0, 3,  1, 0, 0, 0,  0, -1, -1, 5,  4};
      vecs[3] = '{2'd0, 2, 2, 0,  1, 1, 0, 2,  0, -1, -1, 1,  -1};
      vecs[4] = '{2'd1, 2, 0, 2,  3, 0, 0, 2,  2, 2,  5,  9,  9};
      vecs[5] = '{2'd2, 0, 2, 1,  7, 3, 0, 3,  3, 1,  7,  8,  -1};
`ifdef SCHED_STREAM_TX_BYPASS_EN
      vecs[6] = '{2'd1, 0, 0, 2,  1, 0, 2, 1,  1, 2,  2,  3,  -1};
`else
      vecs[6] = '{2'd1, 0, 0, 2,  1, 0, 2, 1,  0, -1, -1, 3,  3};
`endif

      for (int v = 0; v < 7; v++) begin
         run_cfg(vecs[v].dim, vecs[v].r0, vecs[v].r1, vecs[v].st, vecs[v].s0,
                 vecs[v].s1, vecs[v].push_start, vecs[v].npush, -1, 0, 30);
         check_summary($sformatf("vec%0d", v), vecs[v].nrel, vecs[v].first,
                       vecs[v].last, vecs[v].done_cyc, vecs[v].uf_cyc);
      end

      // Tile disabled for 5 cycles: schedule slides by 5, nothing is lost.
      run_cfg(2'd1, 3, 0, 10, 2, 0, 1, 4, 6, 5, 30);
      check_summary("enable_gap", 4, 15, 21, 22, -1);

      // Backpressure: stream always valid, first slot sees a full FIFO.
      do_reset(2'd1, 1, 0, 12, 5, 0);
      for (int s = 0; s < 21; s++) begin
         step(1'b1, 1'b1, data_t'(16'hA000 + s));
      end
      chk("bp_ready_3", {31'b0, rdy_hist[3]}, 32'd1);
      chk("bp_ready_full", {31'b0, rdy_hist[4]}, 32'd0);
      chk("bp_ready_at_match", {31'b0, rdy_hist[12]}, 32'd0);
      chk("bp_valid_at_match", {31'b0, vld_hist[12]}, 32'd1);
      chk("bp_data_at_match", {16'b0, dat_hist[12]}, 32'hA000);
      chk("bp_ready_after", {31'b0, rdy_hist[13]}, 32'd1);
      chk("bp_second_word", {16'b0, dat_hist[17]}, 32'hA001);

      // Reset in the middle of a run with data queued and both flags set.
      do_reset(2'd1, 3, 0, 2, 3, 0);
      for (int s = 0; s < 12; s++) begin
         vin = (s == 0) || (s >= 6 && s <= 9);
         step(1'b1, vin, data_t'(16'hA000 + s));
      end
      #2;
      chk("pre_rst_done", {31'b0, done}, 32'd1);
      chk("pre_rst_underflow", {31'b0, underflow}, 32'd1);
      chk("pre_rst_head", {16'b0, data_out}, 32'hA008);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {31'b0, valid_out}, 32'd0);
      chk("mid_rst_ready", {31'b0, ready_out}, 32'd0);
      chk("mid_rst_done", {31'b0, done}, 32'd0);
      chk("mid_rst_underflow", {31'b0, underflow}, 32'd0);
      chk("mid_rst_empty", {16'b0, data_out}, 32'd0);
      run_cfg(2'd1, 3, 0, 10, 2, 0, 1, 4, -1, 0, 20);
      check_summary("after_rst", 4, 10, 16, 17, -1);

      // Randomized configurations and traffic against the model.
      for (int r = 0; r < 25; r++) begin
         do_reset(2'($urandom_range(0, 2)), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 20), $urandom_range(1, 4), $urandom_range(1, 6));
         for (int s = 0; s < 130; s++) begin
            en  = ($urandom_range(0, 7) != 0);
            vin = ($urandom_range(0, 3) != 0);
            step(en, vin, data_t'($urandom));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
